// File: rtl/morph_filter_pkg.sv
// Shared constants for the binary morphological filter: mode codes, pipeline
// latency, padding value and the sync bundle carried down the delay line.
package morph_filter_pkg;

  localparam logic [1:0] MODE_ERO  = 2'b00;
  localparam logic [1:0] MODE_DIL  = 2'b01;
  localparam logic [1:0] MODE_GRAD = 2'b10;
  localparam logic [1:0] MODE_BYP  = 2'b11;

  localparam int LAT = 3;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  // Neutral element of the reduction: 1 for AND (erosion), 0 otherwise.
  function automatic logic pad_val(input logic [1:0] m);
    return (m == MODE_ERO);
  endfunction

endpackage

// File: rtl/morph_filter_line_buf.sv
// Column-shift line buffer: each address holds the last ROWS pixels seen at that
// column, read combinationally before the same-cycle write.
module morph_filter_line_buf #(
  parameter int ROWS  = 2,
  parameter int DEPTH = 1920,
  parameter int CNT_W = 12
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [CNT_W-1:0] addr_i,
  input  logic             din_i,
  output logic [ROWS-1:0]  taps_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEPTH);

  logic [ROWS-1:0] mem [DEPTH];
  logic            hit;
  logic [AW-1:0]   idx;

  assign hit    = (addr_i < LIM);
  assign idx    = addr_i[AW-1:0];
  assign taps_o = hit ? mem[idx] : '0;

  // Bit 0 is the previous line, bit ROWS-1 the oldest.
  always_ff @(posedge clk_i) begin
    if (we_i && hit) mem[idx] <= {mem[idx][ROWS-2:0], din_i};
  end

endmodule

// File: rtl/morph_filter.sv
// Binary erosion/dilation/bypass over a KSIZE x KSIZE window, 3-clock latency.
// Define MORPH_GRADIENT_EN to add mode 10 = dilate XOR erode.
module morph_filter
  import morph_filter_pkg::*;
#(
  parameter int KSIZE    = 3,
  parameter int H_ACTIVE = 1920,
  parameter int CNT_W    = 12
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic [1:0]  mode,
  input  logic        bin_de,
  input  logic        bin_hs,
  input  logic        bin_vs,
  input  logic        bin_data,
  output logic        morph_de,
  output logic        morph_hs,
  output logic        morph_vs,
  output logic [23:0] data_morph
);

  localparam int R = KSIZE / 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(H_ACTIVE);

  logic                        de_prev_q, vs_prev_q;
  logic [CNT_W-1:0]            col_q, col_d, row_q, row_d, cur_col;
  logic                        de_rise, de_fall, in_range;
  logic [1:0]                  mode_q, mode_eff, mode_s1_q, mode_s2_q;
  logic [KSIZE-2:0]            taps;
  logic [KSIZE-1:0]            col_vec;
  logic [KSIZE-1:0][KSIZE-1:0] win_q, vmask_q, vmask_d;
  logic [KSIZE-1:0]            row_a_d, row_a_q;
  logic                        ctr_q, res;
  sync_t                       sync_in;
  sync_t [LAT-1:0]             sync_q;
  logic [23:0]                 data_q;

  assign de_rise  = bin_de & ~de_prev_q;
  assign de_fall  = ~bin_de & de_prev_q;
  assign cur_col  = de_rise ? '0 : col_q;
  assign in_range = (cur_col < H_LIM);

  always_comb begin
    col_d = col_q;
    if (bin_de) col_d = (cur_col == CNT_MAX) ? cur_col : cur_col + 1'b1;
    row_d = row_q;
    if (bin_vs)                           row_d = '0;
    else if (de_fall && row_q != CNT_MAX) row_d = row_q + 1'b1;
  end

  morph_filter_line_buf #(
    .ROWS (KSIZE-1),
    .DEPTH(H_ACTIVE),
    .CNT_W(CNT_W)
  ) u_lbuf (
    .clk_i (video_clk),
    .we_i  (bin_de & in_range),
    .addr_i(cur_col),
    .din_i (bin_data),
    .taps_o(taps)
  );

  assign col_vec = {taps, bin_data};

  // Cell (r,j) is input pixel (row-r, col-j); cells before the frame origin,
  // and every cell of a dropped pixel, are masked to the pad value.
  always_comb begin
    vmask_d = '0;
    for (int r = 0; r < KSIZE; r++)
      for (int j = 0; j < KSIZE; j++)
        vmask_d[r][j] = in_range && (cur_col >= CNT_W'(j)) && (row_q >= CNT_W'(r));
  end

`ifdef MORPH_GRADIENT_EN
  assign mode_eff = mode_q;

  logic [KSIZE-1:0] row_b_d, row_b_q;
  always_comb begin
    row_a_d = '0;
    row_b_d = '0;
    for (int r = 0; r < KSIZE; r++) begin
      row_a_d[r] = &((win_q[r] & vmask_q[r]) | ({KSIZE{pad_val(MODE_ERO)}} & ~vmask_q[r]));
      row_b_d[r] = |((win_q[r] & vmask_q[r]) | ({KSIZE{pad_val(MODE_DIL)}} & ~vmask_q[r]));
    end
  end
`else
  assign mode_eff = (mode_q == MODE_GRAD) ? MODE_BYP : mode_q;

  // Dilation runs on the AND tree in the inverted domain (OR = ~AND(~x)).
  logic inv;
  assign inv = (mode_s1_q != MODE_ERO);
  always_comb begin
    row_a_d = '0;
    for (int r = 0; r < KSIZE; r++)
      row_a_d[r] = &(((win_q[r] & vmask_q[r]) |
                      ({KSIZE{pad_val(mode_s1_q)}} & ~vmask_q[r])) ^ {KSIZE{inv}});
  end
`endif

  always_comb begin
    res = ctr_q;
    case (mode_s2_q)
      MODE_ERO:  res = &row_a_q;
`ifdef MORPH_GRADIENT_EN
      MODE_DIL:  res = |row_b_q;
      MODE_GRAD: res = (|row_b_q) ^ (&row_a_q);
`else
      MODE_DIL:  res = ~(&row_a_q);
`endif
      default:   res = ctr_q;
    endcase
  end

  assign sync_in = {bin_de, bin_hs, bin_vs};

  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      de_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= MODE_ERO;
      win_q     <= '0;
      vmask_q   <= '0;
      mode_s1_q <= MODE_ERO;
      mode_s2_q <= MODE_ERO;
      row_a_q   <= '0;
`ifdef MORPH_GRADIENT_EN
      row_b_q   <= '0;
`endif
      ctr_q     <= 1'b0;
      sync_q    <= '0;
      data_q    <= '0;
    end else begin
      de_prev_q <= bin_de;
      vs_prev_q <= bin_vs;
      col_q     <= col_d;
      row_q     <= row_d;
      if (bin_vs && !vs_prev_q) mode_q <= mode;
      // stage 0: window shift
      if (bin_de)
        for (int r = 0; r < KSIZE; r++) win_q[r] <= {win_q[r][KSIZE-2:0], col_vec[r]};
      vmask_q   <= vmask_d;
      mode_s1_q <= mode_eff;
      // stage 1: per-row reduce
      row_a_q   <= row_a_d;
`ifdef MORPH_GRADIENT_EN
      row_b_q   <= row_b_d;
`endif
      ctr_q     <= vmask_q[R][R] & win_q[R][R];
      mode_s2_q <= mode_s1_q;
      // stage 2: column reduce and output register
      sync_q    <= {sync_q[LAT-2:0], sync_in};
      data_q    <= sync_q[LAT-2].de ? {24{res}} : '0;
    end
  end

  assign morph_de   = sync_q[LAT-1].de;
  assign morph_hs   = sync_q[LAT-1].hs;
  assign morph_vs   = sync_q[LAT-1].vs;
  assign data_morph = data_q;

endmodule

// File: tb/tb_morph_filter.sv
// Self-checking bench for morph_filter: frame-level image model in a 2-D array,
// expected outputs queued and compared three clocks later.
module tb_morph_filter;

  localparam int K    = 3;
  localparam int R    = K / 2;
  localparam int H    = 16;
  localparam int CW   = 5;
  localparam int CMAX = (1 << CW) - 1;
  localparam int MAXR = 24;
  localparam int MAXC = 24;

  localparam logic [1:0] ERO = 2'b00, DIL = 2'b01, GRD = 2'b10, BYP = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        de = 1'b0, hs = 1'b0, vs = 1'b0, din = 1'b0;
  logic        morph_de, morph_hs, morph_vs;
  logic [23:0] data_morph;

  always #5 clk = ~clk;

  morph_filter #(.KSIZE(K), .H_ACTIVE(H), .CNT_W(CW)) dut (
    .video_clk (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .bin_de    (de),
    .bin_hs    (hs),
    .bin_vs    (vs),
    .bin_data  (din),
    .morph_de  (morph_de),
    .morph_hs  (morph_hs),
    .morph_vs  (morph_vs),
    .data_morph(data_morph)
  );

  typedef struct packed {
    logic [2:0] sync;
    logic       known;
    logic       bit_v;
  } exp_t;

  exp_t       expq[$];
  logic       img [MAXR][MAXC];
  int         m_x, m_y;
  logic       m_pde, m_pvs;
  logic [1:0] m_mode;
  logic       rnd_phase = 1'b0;
  int         n_checks = 0, n_err = 0, cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, got, want);
    end
  endtask

  // Window spans rows y-2R..y, cols x-2R..x; out-of-frame cells are ignored
  // (pad 1 for AND, 0 for OR); a dropped pixel has every cell out of frame.
  function automatic logic ref_px(input int y, input int x, input logic [1:0] md);
    logic ero = 1'b1, dil = 1'b0, ctr = 1'b0;
    if (x < H) begin
      for (int r = 0; r < K; r++)
        for (int j = 0; j < K; j++)
          if (y - r >= 0 && x - j >= 0) begin
            ero = ero & img[y-r][x-j];
            dil = dil | img[y-r][x-j];
          end
      if (y >= R && x >= R) ctr = img[y-R][x-R];
    end
    case (md)
      ERO:     return ero;
      DIL:     return dil;
`ifdef MORPH_GRADIENT_EN
      GRD:     return ero ^ dil;
`endif
      default: return ctr;
    endcase
  endfunction

  task automatic model_reset();
    m_x = 0; m_y = 0; m_pde = 1'b0; m_pvs = 1'b0; m_mode = ERO;
    expq.delete();
    expq.push_back('0);
    expq.push_back('0);
  endtask

  task automatic step(input logic d_de, input logic d_hs, input logic d_vs, input logic d_px);
    exp_t e;
    int   cx;
    de = d_de; hs = d_hs; vs = d_vs; din = d_px;
    cx = (d_de && !m_pde) ? 0 : m_x;
    e = '0;
    e.sync = {d_de, d_hs, d_vs};
    if (d_de) begin
      if (cx < H && m_y < MAXR) img[m_y][cx] = d_px;
      if (m_y < MAXR && !rnd_phase) begin
        e.known = 1'b1;
        e.bit_v = ref_px(m_y, cx, m_mode);
      end
      m_x = (cx == CMAX) ? cx : cx + 1;
    end
    if (d_vs)                                 m_y = 0;
    else if (m_pde && !d_de && m_y < CMAX)    m_y = m_y + 1;
    if (d_vs && !m_pvs) m_mode = mode;
    m_pde = d_de; m_pvs = d_vs;
    expq.push_back(e);
    @(posedge clk); #1;
    cyc++;
    e = expq.pop_front();
    check("sync", 32'({morph_de, morph_hs, morph_vs}), 32'(e.sync));
    if (!e.sync[2])    check("blank_data", 32'(data_morph), 32'd0);
    else if (e.known)  check("pixel", 32'(data_morph), 32'({24{e.bit_v}}));
  endtask

  function automatic logic pix(input int pat, input int y, input int x);
    case (pat)
      0:       return 1'b1;
      1:       return !(y == 3 && x == 3);
      2:       return (y == 2 && x == 2);
      4:       return (y >= 2 && y <= 5 && x >= 2 && x <= 5);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic frame(input logic [1:0] md, input logic [1:0] md_mid,
                       input int w, input int h, input int pat);
    mode = md;
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    for (int y = 0; y < h; y++) begin
      if (y == h / 2) mode = md_mid;
      for (int x = 0; x < w; x++) step(1, 0, 0, pix(pat, y, x));
      step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0);
  endtask

  initial begin
    for (int r = 0; r < MAXR; r++)
      for (int c = 0; c < MAXC; c++) img[r][c] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_de",   32'(morph_de),   32'd0);
    check("rst_hs",   32'(morph_hs),   32'd0);
    check("rst_vs",   32'(morph_vs),   32'd0);
    check("rst_data", 32'(data_morph), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    frame(ERO, ERO, 8, 6, 0);     // all ones, 1-padding at borders
    frame(ERO, ERO, 8, 6, 1);     // single hole grows to 3x3
    frame(DIL, DIL, 8, 6, 2);     // single dot grows to 3x3
    frame(ERO, DIL, 8, 6, 3);     // mid-frame change ignored
    frame(DIL, DIL, 8, 6, 3);     // takes effect at next vs
    frame(ERO, ERO, 18, 5, 3);    // pixels past H_ACTIVE dropped
    frame(DIL, DIL, 18, 5, 3);
    frame(BYP, BYP, 10, 5, 3);
    frame(GRD, GRD, 10, 5, 3);
`ifdef MORPH_GRADIENT_EN
    frame(GRD, GRD, 8, 8, 4);
`endif

    // free-running random syncs: alignment and blanking only
    rnd_phase = 1'b1;
    repeat (300)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    rnd_phase = 1'b0;
    repeat (3) step(0, 0, 0, 0);

    // reset in the middle of a line
    mode = DIL;
    frame(DIL, DIL, 8, 2, 3);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    for (int x = 0; x < 8; x++) step(1, 0, 0, 1'($urandom_range(0, 1)));
    step(0, 1, 0, 0);
    for (int x = 0; x < 4; x++) step(1, 0, 0, 1'b1);
    rst_n = 1'b0;
    de = 1'b0; hs = 1'b0; vs = 1'b0; din = 1'b0;
    #1;
    check("mid_rst_de",   32'(morph_de),   32'd0);
    check("mid_rst_data", 32'(data_morph), 32'd0);
    @(posedge clk); #1;
    check("mid_rst_de2",  32'(morph_de),   32'd0);
    @(posedge clk); #1;
    check("mid_rst_data2", 32'(data_morph), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // no vs yet: row padding from row_cnt = 0, mode back to erosion
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 8; x++) step(1, 0, 0, 1'($urandom_range(0, 1)));
      step(0, 1, 0, 0); step(0, 0, 0, 0);
    end
    repeat (3) step(0, 0, 0, 0);
    frame(ERO, ERO, 12, 6, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
